booth_wb_responder: RTL and testbench
=====================================

BOOTH_WB_RESPONDER -- requirements
Module: booth_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000, Wishbone base address; bits [31:8] are compared for decode.
REQ-002 SHALL have port clk, input, 1, sole clock for all logic.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i (input, 1 each) for the Wishbone strobe, cycle and write-enable.
REQ-005 SHALL have ports wbs_sel_i (input, 4), wbs_dat_i (input, 32) and wbs_adr_i (input, 32) for byte selects, write data and address.
REQ-006 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32) for acknowledge and read data.
REQ-007 SHALL have port p, output, 16, last completed signed product, driven to the pads.
REQ-008 SHALL have port io_oeb, output, 16, pad output-enable bar for p.
REQ-009 SHALL have port irq, output, 1, completion interrupt.

Function
REQ-010 SHALL implement a register map selected by adr[3:2] when adr[31:8] equals BASE_ADR[31:8].
- 0x00 CTRL: [0] start (write 1, self-clearing, reads 0); [1] busy (RO); [2] done (RO, write 1 clears); [3] ie (RW).
- 0x04 OPND: [7:0] A, [15:8] B, both signed 8-bit, RW.
- 0x08 PROD: [15:0] product, RO.
REQ-011 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after stb&cyc&!ack is sampled high. Consecutive accesses are therefore acked no more often than every other cycle.
REQ-012 SHALL return wbs_dat_o in the ack cycle; unused bits and unmapped offsets (0x0C) read 0.
REQ-013 SHALL ack writes to unmapped offsets and ignore their data.
REQ-014 SHALL NOT ack accesses whose adr[31:8] does not match BASE_ADR.
REQ-015 SHALL apply OPND writes per byte lane: sel[0] writes A and sel[1] writes B.
REQ-016 SHALL apply CTRL writes only when sel[0] is 1.
REQ-017 SHALL run the FSM with states IDLE, CALC and DONE.
- IDLE->CALC on a CTRL write with start=1 in IDLE or DONE.
- CALC lasts exactly 4 cycles, then moves to DONE.
- DONE->CALC on a new start.
REQ-018 SHALL ignore a start write, and any OPND write, while busy (state CALC); such accesses are still acked.
REQ-019 SHALL latch A and B at the start-accept cycle T.
REQ-020 SHALL hold busy=1 in cycles T+1..T+4; PROD, p and done=1 SHALL be valid from T+5.
REQ-021 SHALL compute the product by radix-4 Booth recoding.
- Iteration i (0..3) examines {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
- It adds 0, +A, +2A, -A or -2A, sign-extended to 16 bits and shifted left 2i.
REQ-022 SHALL produce an exact 16-bit two's-complement product for all 65536 operand pairs, with no saturation.
REQ-023 SHALL hold PROD and p between completions; a new start SHALL NOT disturb them until the next completion.
REQ-024 SHALL clear done when a new start is accepted.
REQ-025 SHALL give priority to setting done when a done-clear write occurs in the same cycle that done sets.
REQ-026 SHALL drive irq = done & ie, registered.

Reset
REQ-027 SHALL, when reset is sampled high, set state=IDLE and clear A, B, PROD, p, done, ie, irq and wbs_ack_o to 0, and set wbs_dat_o to 0.
REQ-028 SHALL hold io_oeb at 16'hFFFF while reset is asserted and set it to 16'h0000 in the first cycle after reset deasserts.
REQ-029 SHALL abort a calculation in progress on reset mid-CALC, with no done and no irq afterwards.
REQ-030 SHALL drop any Wishbone access pending at reset without an ack.

Structure
REQ-031 SHALL place the register offsets, CTRL bit positions, the state encoding and the iteration count (4) in the shared package booth_pkg.
REQ-032 SHALL implement the Booth datapath (operand latch, recoder, accumulator, iteration counter, FSM) as sub-module booth_r4_core, with ports start, a, b, busy, done_pulse and prod.
REQ-033 SHALL keep the Wishbone decode, register file and irq logic in the top level; the total SHALL be 120-400 lines of RTL.

Verification
REQ-034 SHALL cover: write OPND=0x00FD07 (A=7, B=-3), then CTRL=0x1 -> busy for 4 cycles, PROD=0xFFEB, p=16'hFFEB at T+5.
REQ-035 SHALL cover: A=0x80, B=0x80 -> PROD=0x4000; A=0x7F, B=0x80 -> PROD=0xC080; A=0, B=0x55 -> PROD=0x0000.
REQ-036 SHALL cover: start at T, a second start plus OPND=0x0202 at T+2 -> both acked and ignored; PROD equals the first result and busy falls after exactly 4 cycles.
REQ-037 SHALL cover: ie=1, complete an operation -> irq=1; write CTRL=0x4 -> done=0 and irq=0 the following cycle.
REQ-038 SHALL cover: reset asserted at T+2 of CALC -> state IDLE, PROD=0, done and irq stay 0, io_oeb=16'hFFFF during reset.
REQ-039 SHALL cover: read at BASE+0x0C -> acked with data 0; access at BASE+0x100 -> no ack within 8 cycles; a random 1000-pair sweep SHALL match a signed reference multiply.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared register map, control bits, FSM encoding and Booth helper
package booth_pkg;

    // Register offsets, selected by adr[3:2]
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_OPND = 2'd1;
    localparam logic [1:0] REG_PROD = 2'd2;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_IE    = 3;

    // Radix-4 Booth on an 8-bit multiplier needs four digit iterations
    localparam int NUM_ITER = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } booth_state_e;

    // Partial product for one Booth digit {b[2i+1], b[2i], b[2i-1]}, unshifted
    function automatic logic [15:0] booth_pp(input logic [2:0] trip, input logic [7:0] a);
        logic [15:0] a_ext;
        a_ext = {{8{a[7]}}, a};
        case (trip)
            3'b001, 3'b010: booth_pp = a_ext;
            3'b011:         booth_pp = a_ext << 1;
            3'b100:         booth_pp = -(a_ext << 1);
            3'b101, 3'b110: booth_pp = -a_ext;
            default:        booth_pp = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_core.sv
// rtl/booth_r4_core.sv - radix-4 Booth multiplier core: operand latch, recoder, accumulator, FSM
module booth_r4_core
    import booth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done_pulse,
    output logic [15:0] prod
);

    localparam logic [1:0] LAST_ITER = 2'(NUM_ITER - 1);

    booth_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [7:0]   a_q, a_d;
    logic [7:0]   b_q, b_d;
    logic [15:0]  acc_q, acc_d;
    logic [15:0]  prod_q, prod_d;

    logic [8:0]   b_ext;
    logic [2:0]   trip;
    logic [15:0]  pp_sh;
    logic [15:0]  sum;

    // Appending a zero below the multiplier supplies b[-1] for the first digit
    assign b_ext = {b_q, 1'b0};
    assign trip  = b_ext[{cnt_q, 1'b0} +: 3];
    assign pp_sh = booth_pp(trip, a_q) << {cnt_q, 1'b0};
    assign sum   = acc_q + pp_sh;

    // Next-state logic: one Booth digit per CALC cycle, result published on the last one
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        done_pulse = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CALC;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    cnt_d   = 2'd0;
                end
            end
            ST_CALC: begin
                acc_d = sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d    = ST_DONE;
                    prod_d     = sum;
                    done_pulse = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any calculation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = (state_q == ST_CALC);
    assign prod = prod_q;

endmodule

// File: rtl/booth_wb_responder.sv
// rtl/booth_wb_responder.sv - Wishbone register front end for the radix-4 Booth multiplier
module booth_wb_responder
    import booth_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] p,
    output logic [15:0] io_oeb,
    output logic        irq
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;
    logic        irq_q, irq_d;
    logic [15:0] oeb_q;

    logic        busy;
    logic        done_pulse;
    logic [15:0] prod;

    logic        req;
    logic [1:0]  reg_sel;
    logic        ctrl_wr;
    logic        opnd_wr;
    logic        start;
    logic [31:0] rdata;
    logic        unused_ok;

    // A new request is only taken when not already acking, so acks are single-cycle
    assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign reg_sel = wbs_adr_i[3:2];
    assign ctrl_wr = req & wbs_we_i & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    assign opnd_wr = req & wbs_we_i & (reg_sel == REG_OPND) & ~busy;
    assign start   = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;

    assign unused_ok = ^{wbs_adr_i[7:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

    booth_r4_core u_core (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a_q),
        .b          (b_q),
        .busy       (busy),
        .done_pulse (done_pulse),
        .prod       (prod)
    );

    // Read mux; start always reads back as 0 and unmapped offsets read 0
    always_comb begin
        rdata = 32'h0000_0000;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_BUSY] = busy;
                rdata[CTRL_DONE] = done_q;
                rdata[CTRL_IE]   = ie_q;
            end
            REG_OPND: rdata = {16'h0000, b_q, a_q};
            REG_PROD: rdata = {16'h0000, prod};
            default:  rdata = 32'h0000_0000;
        endcase
    end

    // Register-file next state; a completing calculation beats a same-cycle done clear
    always_comb begin
        ack_d  = req;
        dat_d  = (req & ~wbs_we_i) ? rdata : 32'h0000_0000;
        a_d    = a_q;
        b_d    = b_q;
        ie_d   = ie_q;
        done_d = done_q;
        if (opnd_wr && wbs_sel_i[0]) begin
            a_d = wbs_dat_i[7:0];
        end
        if (opnd_wr && wbs_sel_i[1]) begin
            b_d = wbs_dat_i[15:8];
        end
        if (ctrl_wr) begin
            ie_d = wbs_dat_i[CTRL_IE];
            if (wbs_dat_i[CTRL_DONE]) begin
                done_d = 1'b0;
            end
        end
        if (start) begin
            done_d = 1'b0;
        end
        if (done_pulse) begin
            done_d = 1'b1;
        end
        irq_d = done_d & ie_d;
    end

    // Bus, register file and pad-enable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q  <= 1'b0;
            dat_q  <= 32'h0000_0000;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            irq_q  <= 1'b0;
            oeb_q  <= 16'hFFFF;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            irq_q  <= irq_d;
            oeb_q  <= 16'h0000;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign p         = prod;
    assign io_oeb    = oeb_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_booth_wb_responder.sv
// tb/tb_booth_wb_responder.sv - self-checking bench for booth_wb_responder
module tb_booth_wb_responder;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [15:0] p;
    logic [15:0] io_oeb;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_prod;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    booth_wb_responder #(.BASE_ADR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .p         (p),
        .io_oeb    (io_oeb),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [15:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected none (scoreboard empty)", name, act);
        end else begin
            chk(name, {16'h0, act}, {16'h0, exp_q.pop_front()});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit exp_ack, output logic [31:0] rd);
        int n;
        bit acked;
        if (wbs_ack_o === 1'b1) tick();
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        n = 0;
        acked = 1'b0;
        rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                rd = wbs_dat_o;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (exp_ack) chk("ack_latency", n, 1);
        else         chk("unmapped_no_ack", {31'b0, acked}, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        wb_access(1'b1, BASE + off, dat, sel, 1'b1, rd);
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
        wb_access(1'b0, BASE + off, 32'h0, 4'hF, 1'b1, rd);
    endtask

    // Start an op with ie=1 and check p/irq cycle by cycle from T+1 to T+5
    task automatic run_timed(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                             input string name);
        logic [31:0] rd;
        wb_write(32'h4, {16'h0, b, a}, 4'hF);
        wb_write(32'h0, 32'h9, 4'hF);
        exp_q.push_back(exp);
        for (int k = 1; k <= 4; k++) begin
            chk({name, "_p_hold"}, {16'h0, p}, {16'h0, last_prod});
            chk({name, "_irq_low"}, {31'b0, irq}, 32'd0);
            if (k < 4) tick();
        end
        tick();
        chk({name, "_irq_t5"}, {31'b0, irq}, 32'd1);
        pop_check({name, "_p_t5"}, p);
        last_prod = exp;
        wb_read(32'h8, rd);
        chk({name, "_prod_reg"}, rd, {16'h0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  ra, rb;
        logic [15:0] rexp;
        int          ia, ib;
        bit          seen;

        vecs[0] = '{8'h07, 8'hFD, 16'hFFEB};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'h80, 16'hC080};
        vecs[3] = '{8'h00, 8'h55, 16'h0000};
        vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[6] = '{8'h80, 8'h7F, 16'hC080};
        vecs[7] = '{8'h01, 8'h80, 16'hFF80};
        vecs[8] = '{8'h55, 8'hAA, 16'hE372};
        vecs[9] = '{8'h80, 8'h01, 16'hFF80};

        reset = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_dat_i = 32'h0;
        wbs_adr_i = 32'h0;
        last_prod = 16'h0;

        // Reset state, with an access pending that must be dropped
        repeat (2) tick();
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_adr_i = BASE;
        tick();
        chk("reset_pending_ack", {31'b0, wbs_ack_o}, 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        chk("reset_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("reset_p", {16'h0, p}, 32'd0);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("reset_dat", wbs_dat_o, 32'd0);
        reset = 1'b0;
        tick();
        chk("oeb_after_reset", {16'h0, io_oeb}, 32'd0);
        wb_read(32'h0, rd); chk("reset_ctrl", rd, 32'd0);
        wb_read(32'h4, rd); chk("reset_opnd", rd, 32'd0);
        wb_read(32'h8, rd); chk("reset_prod", rd, 32'd0);

        // Table-driven products with exact timing
        for (int i = 0; i < 10; i++) begin
            run_timed(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Byte lanes and unmapped offsets
        wb_write(32'h4, 32'h0, 4'hF);
        wb_write(32'h4, 32'hFFFF_1234, 4'b0001);
        wb_read(32'h4, rd); chk("opnd_lane0", rd, 32'h0000_0034);
        wb_write(32'h4, 32'hFFFF_5678, 4'b0010);
        wb_read(32'h4, rd); chk("opnd_lane1", rd, 32'h0000_5634);
        wb_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'h4, rd); chk("unmapped_write_ignored", rd, 32'h0000_5634);
        wb_read(32'hC, rd); chk("unmapped_read_zero", rd, 32'd0);
        wb_write(32'h0, 32'h1, 4'b1110);
        wb_read(32'h0, rd); chk("ctrl_sel0_gate_start", rd, 32'h0000_000C);
        wb_access(1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, rd);

        // Ack lasts one cycle even if strobe stays high
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE;
        tick();
        chk("ack_first", {31'b0, wbs_ack_o}, 32'd1);
        tick();
        chk("ack_single_cycle", {31'b0, wbs_ack_o}, 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;

        // Start and OPND writes while busy are acked and ignored
        wb_write(32'h4, 32'h0000_0506, 4'hF);
        wb_write(32'h0, 32'h9, 4'hF);
        exp_q.push_back(16'h001E);
        wb_write(32'h0, 32'h9, 4'hF);
        wb_write(32'h4, 32'h0000_0202, 4'hF);
        chk("busy_ignore_irq_t5", {31'b0, irq}, 32'd1);
        pop_check("busy_ignore_p_t5", p);
        last_prod = 16'h001E;
        wb_read(32'h4, rd); chk("busy_ignore_opnd", rd, 32'h0000_0506);
        wb_read(32'h8, rd); chk("busy_ignore_prod", rd, 32'h0000_001E);
        wb_read(32'h0, rd); chk("busy_ignore_ctrl", rd, 32'h0000_000C);

        // Done clear and irq
        wb_write(32'h0, 32'h4, 4'b1110);
        chk("ctrl_sel0_gate_irq", {31'b0, irq}, 32'd1);
        wb_read(32'h0, rd); chk("ctrl_sel0_gate_ctrl", rd, 32'h0000_000C);
        wb_write(32'h0, 32'hC, 4'hF);
        chk("done_clear_irq", {31'b0, irq}, 32'd0);
        wb_read(32'h0, rd); chk("done_clear_ctrl", rd, 32'h0000_0008);
        run_timed(8'h03, 8'h04, 16'h000C, "ie_op");
        wb_write(32'h0, 32'h4, 4'hF);
        chk("ctrl4_irq", {31'b0, irq}, 32'd0);
        wb_read(32'h0, rd); chk("ctrl4_ctrl", rd, 32'd0);

        // Done clear in the same cycle that done sets: set wins
        wb_write(32'h4, 32'h0000_0202, 4'hF);
        wb_write(32'h0, 32'h9, 4'hF);
        exp_q.push_back(16'h0004);
        repeat (3) tick();
        wb_write(32'h0, 32'hC, 4'hF);
        chk("done_priority_irq", {31'b0, irq}, 32'd1);
        pop_check("done_priority_p", p);
        last_prod = 16'h0004;
        wb_read(32'h0, rd); chk("done_priority_ctrl", rd, 32'h0000_000C);

        // Reset in the middle of CALC
        wb_write(32'h4, 32'h0000_0305, 4'hF);
        wb_write(32'h0, 32'h9, 4'hF);
        tick();
        reset = 1'b1;
        tick();
        chk("midreset_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        chk("midreset_p", {16'h0, p}, 32'd0);
        chk("midreset_irq", {31'b0, irq}, 32'd0);
        tick();
        chk("midreset_oeb_hold", {16'h0, io_oeb}, 32'h0000_FFFF);
        reset = 1'b0;
        tick();
        chk("midreset_oeb_release", {16'h0, io_oeb}, 32'd0);
        repeat (8) tick();
        chk("midreset_irq_after", {31'b0, irq}, 32'd0);
        chk("midreset_p_after", {16'h0, p}, 32'd0);
        wb_read(32'h0, rd); chk("midreset_ctrl", rd, 32'd0);
        wb_read(32'h8, rd); chk("midreset_prod", rd, 32'd0);
        last_prod = 16'h0;

        // Random sweep against a signed reference multiply
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ia = int'($signed(ra));
            ib = int'($signed(rb));
            rexp = 16'(ia * ib);
            wb_write(32'h4, {16'h0, rb, ra}, 4'hF);
            wb_write(32'h0, 32'h1, 4'hF);
            exp_q.push_back(rexp);
            seen = 1'b0;
            for (int j = 0; j < 12; j++) begin
                wb_read(32'h0, rd);
                if (rd[2]) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("sweep_done_seen", {31'b0, seen}, 32'd1);
            wb_read(32'h8, rd);
            pop_check("sweep_prod", rd[15:0]);
            chk("sweep_p", {16'h0, p}, {16'h0, rexp});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
